// File: rtl/pe_conv_mc.sv
// pe_conv_mc: multi-channel 2-D convolution processing element.
// Weights (CHANNELS x KERNEL x KERNEL) and activations (CHANNELS x ACT_SIZE x ACT_SIZE)
// are streamed into local scratchpads. On start, every strided output pixel is computed
// with a channel-accumulated MAC, one product per cycle, and then emitted saturated.
// Weights are kept across runs. Activations must be reloaded for every run.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   wght_in/valid/ready         weight load stream (channel-major, then row-major)
//   act_in/valid/ready          activation load stream (channel-major, then row-major)
//   start, busy                 run request, run in progress
//   out_data/valid/ready        saturated output pixels in raster order
//   done, start_err             end-of-run pulse, start-while-not-loaded pulse
module pe_conv_mc #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ACC_W    = 40,
  parameter int unsigned KERNEL   = 3,
  parameter int unsigned ACT_SIZE = 5,
  parameter int unsigned STRIDE   = 1,
  parameter int unsigned CHANNELS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wght_in,
  input  logic              wght_valid,
  output logic              wght_ready,
  input  logic [DATA_W-1:0] act_in,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              start_err
);

  localparam int unsigned OUT_DIM = (ACT_SIZE - KERNEL) / STRIDE + 1;
  localparam int unsigned NW      = CHANNELS * KERNEL * KERNEL;
  localparam int unsigned NA      = CHANNELS * ACT_SIZE * ACT_SIZE;
  localparam int unsigned WA      = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned AA      = (NA > 1) ? $clog2(NA) : 1;
  localparam int unsigned KW      = $clog2(KERNEL + 1);
  localparam int unsigned CW      = $clog2(CHANNELS + 1);
  localparam int unsigned OW      = $clog2(OUT_DIM + 1);
  localparam int unsigned PW      = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_e;

  state_e                    state_q, state_d;
  logic [WA-1:0]             wcnt_q, wcnt_d;
  logic [AA-1:0]             acnt_q, acnt_d;
  logic                      wght_loaded_q, wght_loaded_d;
  logic                      act_loaded_q, act_loaded_d;
  logic [KW-1:0]             kx_q, kx_d, ky_q, ky_d;
  logic [CW-1:0]             c_q, c_d;
  logic [OW-1:0]             ox_q, ox_d, oy_q, oy_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      start_err_q, start_err_d;
  logic                      wght_ready_q, wght_ready_d;
  logic                      act_ready_q, act_ready_d;

  logic signed [DATA_W-1:0]  wmem [NW];
  logic signed [DATA_W-1:0]  amem [NA];

  logic                      w_we, a_we;
  logic [WA-1:0]             w_addr;
  logic [AA-1:0]             a_addr;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   mac_sum;
  logic [DATA_W-1:0]         sat_val;

  assign w_we = wght_valid & wght_ready_q & ~reset;
  assign a_we = act_valid & act_ready_q & ~reset;

  // Scratchpad writes; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_we) wmem[wcnt_q] <= wght_in;
    if (a_we) amem[acnt_q] <= act_in;
  end

  // Operand addressing for the current (c, ky, kx) tap of output pixel (oy, ox).
  always_comb begin
    w_addr = WA'(32'(c_q) * KERNEL * KERNEL + 32'(ky_q) * KERNEL + 32'(kx_q));
    a_addr = AA'(32'(c_q) * ACT_SIZE * ACT_SIZE
                 + (32'(oy_q) * STRIDE + 32'(ky_q)) * ACT_SIZE
                 + 32'(ox_q) * STRIDE + 32'(kx_q));
    prod    = PW'(wmem[w_addr]) * PW'(amem[a_addr]);
    mac_sum = acc_q + ACC_W'(prod);
    if (mac_sum > SAT_MAX)      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
    else if (mac_sum < SAT_MIN) sat_val = {1'b1, {(DATA_W-1){1'b0}}};
    else                        sat_val = mac_sum[DATA_W-1:0];
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    acnt_d        = acnt_q;
    wght_loaded_d = wght_loaded_q;
    act_loaded_d  = act_loaded_q;
    kx_d          = kx_q;
    ky_d          = ky_q;
    c_d           = c_q;
    ox_d          = ox_q;
    oy_d          = oy_q;
    acc_d         = acc_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    start_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_we) begin
          if (wcnt_q == WA'(NW - 1)) begin
            wcnt_d        = '0;
            wght_loaded_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WA'(1);
          end
        end
        if (a_we) begin
          if (acnt_q == AA'(NA - 1)) begin
            acnt_d       = '0;
            act_loaded_d = 1'b1;
          end else begin
            acnt_d = acnt_q + AA'(1);
          end
        end
        if (start) begin
          if (wght_loaded_q && act_loaded_q) begin
            state_d = MAC;
            busy_d  = 1'b1;
            acc_d   = '0;
            kx_d    = '0;
            ky_d    = '0;
            c_d     = '0;
            ox_d    = '0;
            oy_d    = '0;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end

      MAC: begin
        acc_d = mac_sum;
        // kx innermost, then ky, then channel; last tap hands the sum to EMIT.
        if (kx_q == KW'(KERNEL - 1)) begin
          kx_d = '0;
          if (ky_q == KW'(KERNEL - 1)) begin
            ky_d = '0;
            if (c_q == CW'(CHANNELS - 1)) begin
              c_d         = '0;
              state_d     = EMIT;
              out_valid_d = 1'b1;
              out_data_d  = sat_val;
            end else begin
              c_d = c_q + CW'(1);
            end
          end else begin
            ky_d = ky_q + KW'(1);
          end
        end else begin
          kx_d = kx_q + KW'(1);
        end
      end

      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = MAC;
          if (ox_q == OW'(OUT_DIM - 1)) begin
            ox_d = '0;
            if (oy_q == OW'(OUT_DIM - 1)) begin
              oy_d         = '0;
              state_d      = IDLE;
              busy_d       = 1'b0;
              done_d       = 1'b1;
              act_loaded_d = 1'b0;
            end else begin
              oy_d = oy_q + OW'(1);
            end
          end else begin
            ox_d = ox_q + OW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    wght_ready_d = (state_d == IDLE) && !wght_loaded_d;
    act_ready_d  = (state_d == IDLE) && !act_loaded_d;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      acnt_q        <= '0;
      wght_loaded_q <= 1'b0;
      act_loaded_q  <= 1'b0;
      kx_q          <= '0;
      ky_q          <= '0;
      c_q           <= '0;
      ox_q          <= '0;
      oy_q          <= '0;
      acc_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      start_err_q   <= 1'b0;
      wght_ready_q  <= 1'b0;
      act_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      acnt_q        <= acnt_d;
      wght_loaded_q <= wght_loaded_d;
      act_loaded_q  <= act_loaded_d;
      kx_q          <= kx_d;
      ky_q          <= ky_d;
      c_q           <= c_d;
      ox_q          <= ox_d;
      oy_q          <= oy_d;
      acc_q         <= acc_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      start_err_q   <= start_err_d;
      wght_ready_q  <= wght_ready_d;
      act_ready_q   <= act_ready_d;
    end
  end

  assign wght_ready = wght_ready_q;
  assign act_ready  = act_ready_q;
  assign busy       = busy_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign start_err  = start_err_q;

endmodule

// File: tb/tb_pe_conv_mc.sv
// tb_pe_conv_mc: directed bench for pe_conv_mc.
// Instance a: KERNEL=3, ACT_SIZE=5, CHANNELS=2, STRIDE=1.
// Instance b: KERNEL=3, ACT_SIZE=5, CHANNELS=1, STRIDE=2 (strided run and mid-run reset).
// Expected pixels come from a direct nested-loop convolution of the loaded tables.
module tb_pe_conv_mc;

  localparam int K   = 3;
  localparam int A   = 5;
  localparam int CH  = 2;
  localparam int NW  = CH * K * K;
  localparam int NA  = CH * A * A;
  localparam int NWB = K * K;
  localparam int NAB = A * A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_wv, a_wr, a_av, a_ar, a_start, a_busy, a_ov, a_ordy, a_done, a_serr;
  logic [15:0] a_wd, a_ad, a_od;
  logic        b_rst, b_wv, b_wr, b_av, b_ar, b_start, b_busy, b_ov, b_ordy, b_done, b_serr;
  logic [15:0] b_wd, b_ad, b_od;

  pe_conv_mc #(.DATA_W(16), .ACC_W(40), .KERNEL(3), .ACT_SIZE(5), .STRIDE(1), .CHANNELS(2)) dut_a (
    .clk(clk), .reset(a_rst),
    .wght_in(a_wd), .wght_valid(a_wv), .wght_ready(a_wr),
    .act_in(a_ad), .act_valid(a_av), .act_ready(a_ar),
    .start(a_start), .busy(a_busy),
    .out_data(a_od), .out_valid(a_ov), .out_ready(a_ordy),
    .done(a_done), .start_err(a_serr)
  );

  pe_conv_mc #(.DATA_W(16), .ACC_W(40), .KERNEL(3), .ACT_SIZE(5), .STRIDE(2), .CHANNELS(1)) dut_b (
    .clk(clk), .reset(b_rst),
    .wght_in(b_wd), .wght_valid(b_wv), .wght_ready(b_wr),
    .act_in(b_ad), .act_valid(b_av), .act_ready(b_ar),
    .start(b_start), .busy(b_busy),
    .out_data(b_od), .out_valid(b_ov), .out_ready(b_ordy),
    .done(b_done), .start_err(b_serr)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt_a = 0;
  int serr_cnt_a = 0;
  int wv[NW];
  int av[NA];
  int mq[$];
  int qa[$];
  int qb[$];

  task automatic check(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic flag(input string nm, input longint got, input longint exp);
    checks++;
    errors++;
    $display("FAIL %s got %0d expected %0d", nm, got, exp);
  endtask

  function automatic int sat16(input longint s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  // Reference convolution over wv/av into mq.
  task automatic compute(input int ch, input int st);
    int od;
    longint s;
    od = (A - K) / st + 1;
    mq.delete();
    for (int oy = 0; oy < od; oy++)
      for (int ox = 0; ox < od; ox++) begin
        s = 0;
        for (int c = 0; c < ch; c++)
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
              s += longint'(wv[c*K*K + ky*K + kx]) *
                   longint'(av[c*A*A + (oy*st + ky)*A + ox*st + kx]);
        mq.push_back(sat16(s));
      end
  endtask

  function automatic bit rdy(input bit use_b, input bit is_act);
    if (use_b) return is_act ? b_ar : b_wr;
    return is_act ? a_ar : a_wr;
  endfunction

  // Streams table entries [from, to) into one of the load ports.
  task automatic load(input bit use_b, input bit is_act, input int from, input int to);
    int t;
    for (int i = from; i < to; i++) begin
      if (use_b) begin
        if (is_act) begin b_av = 1'b1; b_ad = 16'(av[i]); end
        else        begin b_wv = 1'b1; b_wd = 16'(wv[i]); end
      end else begin
        if (is_act) begin a_av = 1'b1; a_ad = 16'(av[i]); end
        else        begin a_wv = 1'b1; a_wd = 16'(wv[i]); end
      end
      t = 0;
      @(negedge clk);
      while (!rdy(use_b, is_act) && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!rdy(use_b, is_act)) begin
        flag("load_ready_timeout", longint'(i), longint'(to));
        break;
      end
      @(posedge clk); #1;
    end
    a_wv = 1'b0; a_av = 1'b0; b_wv = 1'b0; b_av = 1'b0;
  endtask

  task automatic reset_a();
    a_rst = 1'b1; a_start = 1'b0; a_wv = 1'b0; a_av = 1'b0;
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Pulses start on instance a; returns the cycle offsets (start cycle = 0)
  // of the first out_valid and of done.
  task automatic run_a(output int first_v, output int done_c);
    int cyc;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("busy_after_start", longint'(a_busy), 1);
    cyc = 1; first_v = -1; done_c = -1;
    while (done_c < 0 && cyc < 2000) begin
      if (a_ov && first_v < 0) first_v = cyc;
      if (a_done) done_c = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    if (done_c < 0) flag("run_done_timeout", longint'(cyc), 2000);
    check("run_queue_empty", longint'(qa.size()), 0);
    check("run_busy_low", longint'(a_busy), 0);
  endtask

  // Compares every presented pixel with the head of the expected queue.
  always @(negedge clk) begin
    if (a_done) done_cnt_a++;
    if (a_serr) serr_cnt_a++;
    if (a_ov) begin
      if (qa.size() == 0) flag("a_extra_output", longint'($signed(a_od)), 0);
      else begin
        check("a_pixel", longint'($signed(a_od)), longint'(qa[0]));
        if (a_ordy) void'(qa.pop_front());
      end
    end
    if (b_ov) begin
      if (qb.size() == 0) flag("b_extra_output", longint'($signed(b_od)), 0);
      else begin
        check("b_pixel", longint'($signed(b_od)), longint'(qb[0]));
        if (b_ordy) void'(qb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got 1 expected 0");
    $fatal(1, "watchdog");
  end

  initial begin
    int fv, dc, base, st_t;
    a_rst = 1'b1; a_wv = 1'b0; a_av = 1'b0; a_wd = '0; a_ad = '0; a_start = 1'b0; a_ordy = 1'b1;
    b_rst = 1'b1; b_wv = 1'b0; b_av = 1'b0; b_wd = '0; b_ad = '0; b_start = 1'b0; b_ordy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wght_ready", longint'(a_wr), 0);
    check("rst_act_ready", longint'(a_ar), 0);
    check("rst_out_valid", longint'(a_ov), 0);
    check("rst_out_data", longint'(a_od), 0);
    check("rst_busy", longint'(a_busy), 0);
    check("rst_done", longint'(a_done), 0);
    check("rst_start_err", longint'(a_serr), 0);
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;
    check("idle_wght_ready", longint'(a_wr), 1);
    check("idle_act_ready", longint'(a_ar), 1);

    // Test 1: all ones -> 18 per pixel, latency and throughput.
    foreach (wv[i]) wv[i] = 1;
    foreach (av[i]) av[i] = 1;
    compute(CH, 1);
    check("model_t1_px0", longint'(mq[0]), 18);
    check("model_t1_count", longint'(mq.size()), 9);
    qa = mq;
    load(0, 0, 0, NW);
    load(0, 1, 0, NA);
    check("t1_loaded_wready", longint'(a_wr), 0);
    check("t1_loaded_aready", longint'(a_ar), 0);
    base = done_cnt_a;
    run_a(fv, dc);
    check("t1_first_valid_cycle", longint'(fv), 19);
    check("t1_done_cycle", longint'(dc), 172);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_pulses", longint'(done_cnt_a - base), 1);
    check("t1_weights_kept", longint'(a_wr), 0);
    check("t1_act_reload_ready", longint'(a_ar), 1);

    // Test 2: -1 x 2 -> -36.
    reset_a();
    foreach (wv[i]) wv[i] = -1;
    foreach (av[i]) av[i] = 2;
    compute(CH, 1);
    check("model_t2_px0", longint'(mq[0]), -36);
    qa = mq;
    load(0, 0, 0, NW);
    load(0, 1, 0, NA);
    run_a(fv, dc);

    // Test 3: positive and negative saturation.
    reset_a();
    foreach (wv[i]) wv[i] = 32767;
    foreach (av[i]) av[i] = 32767;
    compute(CH, 1);
    check("model_t3_pos", longint'(mq[0]), 32767);
    qa = mq;
    load(0, 0, 0, NW);
    load(0, 1, 0, NA);
    run_a(fv, dc);
    reset_a();
    foreach (wv[i]) wv[i] = -32768;
    compute(CH, 1);
    check("model_t3_neg", longint'(mq[0]), -32768);
    qa = mq;
    load(0, 0, 0, NW);
    load(0, 1, 0, NA);
    run_a(fv, dc);

    // Test 4: backpressure on pixel 0 with mixed-sign data.
    reset_a();
    foreach (wv[i]) wv[i] = i - 9;
    foreach (av[i]) av[i] = (i % 7) - 3;
    compute(CH, 1);
    qa = mq;
    load(0, 0, 0, NW);
    load(0, 1, 0, NA);
    a_ordy = 1'b0;
    fork
      run_a(fv, dc);
      begin
        st_t = 0;
        while (!a_ov && st_t < 100) begin
          @(posedge clk); #1;
          st_t++;
        end
        check("t4_valid_seen", longint'(a_ov), 1);
        repeat (5) begin
          @(posedge clk); #1;
          check("t4_stall_valid", longint'(a_ov), 1);
        end
        a_ordy = 1'b1;
      end
    join

    // Test 5: early start, then weight reuse across runs.
    reset_a();
    foreach (wv[i]) wv[i] = (i % 5) - 2;
    foreach (av[i]) av[i] = i % 4;
    compute(CH, 1);
    qa = mq;
    load(0, 0, 0, NW);
    load(0, 1, 0, 10);
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("t5_start_err", longint'(a_serr), 1);
    check("t5_busy_low", longint'(a_busy), 0);
    @(posedge clk); #1;
    check("t5_start_err_pulse", longint'(a_serr), 0);
    check("t5_still_idle", longint'(a_ar), 1);
    load(0, 1, 10, NA);
    run_a(fv, dc);
    foreach (av[i]) av[i] = 3 - (i % 6);
    compute(CH, 1);
    qa = mq;
    check("t5_no_weight_reload", longint'(a_wr), 0);
    load(0, 1, 0, NA);
    base = serr_cnt_a;
    fork
      run_a(fv, dc);
      begin
        repeat (40) @(posedge clk);
        #1 a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
      end
    join
    check("t5_busy_start_ignored", longint'(dc), 172);
    check("t5_busy_start_no_err", longint'(serr_cnt_a - base), 0);

    // Test 6: stride 2, single channel, reset during pixel 2.
    for (int i = 0; i < NWB; i++) wv[i] = 1;
    for (int i = 0; i < NAB; i++) av[i] = i;
    compute(1, 2);
    check("model_t6_count", longint'(mq.size()), 4);
    check("model_t6_px0", longint'(mq[0]), 54);
    check("model_t6_px1", longint'(mq[1]), 72);
    check("model_t6_px2", longint'(mq[2]), 144);
    check("model_t6_px3", longint'(mq[3]), 162);
    qb = mq;
    load(1, 0, 0, NWB);
    load(1, 1, 0, NAB);
    b_ordy = 1'b1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    st_t = 0;
    while (qb.size() > 2 && st_t < 200) begin
      @(posedge clk); #1;
      st_t++;
    end
    b_ordy = 1'b0;
    check("t6_two_accepted", longint'(qb.size()), 2);
    st_t = 0;
    while (!b_ov && st_t < 50) begin
      @(posedge clk); #1;
      st_t++;
    end
    check("t6_px2_valid", longint'(b_ov), 1);
    @(posedge clk); #1;
    b_rst = 1'b1;
    @(posedge clk); #1;
    qb.delete();
    check("t6_rst_valid", longint'(b_ov), 0);
    check("t6_rst_data", longint'(b_od), 0);
    check("t6_rst_busy", longint'(b_busy), 0);
    check("t6_rst_wready", longint'(b_wr), 0);
    check("t6_rst_aready", longint'(b_ar), 0);
    check("t6_rst_done", longint'(b_done), 0);
    @(posedge clk); #1;
    b_rst = 1'b0;
    @(posedge clk); #1;
    check("t6_wght_unloaded", longint'(b_wr), 1);
    check("t6_act_unloaded", longint'(b_ar), 1);
    b_ordy = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("t6_no_resume", longint'(b_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
